// File: rtl/trace_pkg.sv
// Shared types for the RVFI trace capture controller.
// Defining TRACE_TIMESTAMP_EN adds a 32-bit cycle timestamp to every record.
package trace_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      STOPPED = 2'd3
   } trace_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] mem_addr;
      logic [3:0]  mem_rmask;
      logic [3:0]  mem_wmask;
`ifdef TRACE_TIMESTAMP_EN
      logic [31:0] timestamp;
`endif
   } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace records; a push into a full FIFO succeeds when a pop
// happens in the same cycle. Head is read combinationally and forced to zero when empty.
module trace_fifo #(
   parameter int  DEPTH = 8,
   parameter type T     = logic [31:0]
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  T                       data_i,
   input  logic                   pop_i,
   output T                       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = empty_o ? T'('0) : mem_q[rd_ptr_q];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/rvfi_trace_ctrl.sv
// Capture window controller between the RVFI retirement port and the tracer sink.
// Optional feature macro: TRACE_TIMESTAMP_EN (free-running cycle stamp on each record).
module rvfi_trace_ctrl
   import trace_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DROP_W = 16
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   cfg_arm,
   input  logic                   cfg_stop,
   input  logic [31:0]            cfg_start_pc,
   input  logic [31:0]            cfg_stop_pc,
   input  logic                   rvfi_valid,
   input  logic [31:0]            rvfi_pc_rdata,
   input  logic [31:0]            rvfi_insn,
   input  logic [31:0]            rvfi_rd_wdata,
   input  logic [31:0]            rvfi_mem_addr,
   input  logic [4:0]             rvfi_rd_addr,
   input  logic [3:0]             rvfi_mem_rmask,
   input  logic [3:0]             rvfi_mem_wmask,
   output logic                   trace_valid,
   input  logic                   trace_ready,
   output trace_rec_t             trace_rec,
   output logic [1:0]             state_o,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [DROP_W-1:0]      drop_cnt,
   output logic                   overflow
);

   trace_state_e      state_q, state_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic              ovf_q, ovf_d;
   logic              start_hit, stop_hit, push_req, pop, full, empty, drop;
   trace_rec_t        rec_in;

`ifdef TRACE_TIMESTAMP_EN
   logic [31:0]       ts_q;
`endif

   always_comb begin
      rec_in           = '0;
      rec_in.pc        = rvfi_pc_rdata;
      rec_in.insn      = rvfi_insn;
      rec_in.rd_addr   = rvfi_rd_addr;
      rec_in.rd_wdata  = rvfi_rd_wdata;
      rec_in.mem_addr  = rvfi_mem_addr;
      rec_in.mem_rmask = rvfi_mem_rmask;
      rec_in.mem_wmask = rvfi_mem_wmask;
`ifdef TRACE_TIMESTAMP_EN
      rec_in.timestamp = ts_q;
`endif
   end

   assign start_hit = rvfi_valid && (rvfi_pc_rdata == cfg_start_pc);
   assign stop_hit  = rvfi_valid && (rvfi_pc_rdata == cfg_stop_pc);
   // cfg_stop suppresses the start-match capture but not an in-window retirement.
   assign push_req  = ((state_q == ARMED) && start_hit && !cfg_stop) ||
                      ((state_q == CAPTURE) && rvfi_valid);
   assign pop       = trace_valid && trace_ready;
   assign drop      = push_req && full && !pop;

   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      ovf_d   = ovf_q;
      if (cfg_stop) begin
         if (state_q != IDLE) state_d = STOPPED;
      end else begin
         case (state_q)
            IDLE, STOPPED: begin
               if (cfg_arm) begin
                  state_d = ARMED;
                  drop_d  = '0;
                  ovf_d   = 1'b0;
               end
            end
            ARMED: begin
               if (start_hit) state_d = (cfg_start_pc == cfg_stop_pc) ? STOPPED : CAPTURE;
            end
            CAPTURE: begin
               if (stop_hit) state_d = STOPPED;
            end
            default: state_d = state_q;
         endcase
      end
      if (drop) begin
         drop_d = (drop_q == '1) ? drop_q : drop_q + DROP_W'(1);
         ovf_d  = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= IDLE;
         drop_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef TRACE_TIMESTAMP_EN
   always_ff @(posedge CLK) begin
      if (!RESET) ts_q <= '0;
      else        ts_q <= ts_q + 32'd1;
   end
`endif

   trace_fifo #(
      .DEPTH (DEPTH),
      .T     (trace_rec_t)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (RESET),
      .push_i  (push_req),
      .data_i  (rec_in),
      .pop_i   (pop),
      .data_o  (trace_rec),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_count)
   );

   assign trace_valid = !empty;
   assign state_o     = state_q;
   assign drop_cnt    = drop_q;
   assign overflow    = ovf_q;

endmodule

// File: doc/rvfi_trace_ctrl.md
# rvfi_trace_ctrl

Trace capture controller between the pipelined CPU's RVFI retirement port and the instruction tracer. It watches retirements, opens and closes a capture window on programmable start/stop PCs, and buffers retired-instruction records in a FIFO. Records drain to the tracer/sink over a valid/ready handshake, so a stalling sink never back-pressures the CPU; records that do not fit are counted and dropped.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- DROP_W, 16: drop-counter width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset; synchronous, active-low.
- cfg_arm  in  1  single-cycle pulse; arms the capture window.
- cfg_stop  in  1  single-cycle pulse; forces the window closed.
- cfg_start_pc  in  32  PC that opens the window.
- cfg_stop_pc  in  32  PC that closes the window.
- rvfi_valid  in  1  retirement strobe.
- rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata, rvfi_mem_addr  in  32 each  retirement fields.
- rvfi_rd_addr  in  5  destination register.
- rvfi_mem_rmask, rvfi_mem_wmask  in  4 each  byte masks.
- trace_valid  out  1  head record valid.
- trace_ready  in  1  sink accepts the head record.
- trace_rec  out  trace_rec_t  head record.
- state_o  out  2  current state.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.
- drop_cnt  out  DROP_W  records dropped; saturates.
- overflow  out  1  sticky; set on any drop.

## Operation
- States:
  - IDLE=0: ignores retirements.
  - ARMED=1: waits for the start PC.
  - CAPTURE=2: pushes every retirement.
  - STOPPED=3: ignores retirements; the FIFO keeps draining.
- Transitions:
  - IDLE/STOPPED → ARMED on cfg_arm. Arming clears drop_cnt and overflow and does not flush the FIFO. cfg_arm in ARMED or CAPTURE is ignored.
  - ARMED → CAPTURE on a retirement with rvfi_pc_rdata==cfg_start_pc. That retirement is captured.
  - CAPTURE → STOPPED on a retirement with rvfi_pc_rdata==cfg_stop_pc. That retirement is captured.
  - If cfg_start_pc==cfg_stop_pc, the matching retirement in ARMED is captured and the state goes straight to STOPPED.
  - Any state → STOPPED on cfg_stop, except IDLE, which stays IDLE.
  - cfg_stop wins over cfg_arm and over a start-PC match in the same cycle. A retirement in that cycle is still captured if the state is CAPTURE.
- Push: a qualifying retirement (the ARMED start match, or any retirement in CAPTURE) requests a push.
  - Push is accepted if the FIFO is not full, or if it is full and a pop happens the same cycle. Simultaneous push and pop leaves the count unchanged.
  - Otherwise the record is dropped: drop_cnt increments (saturating at all ones) and overflow is set.
- Pop: a pop occurs when trace_valid && trace_ready.
- trace_valid = (fifo_count != 0). trace_rec shows the head entry and is meaningful only while trace_valid is high.
- Pointers wrap modulo DEPTH. Occupancy never exceeds DEPTH.

## Timing
- Reset values: state_o=IDLE, fifo_count=0, trace_valid=0, trace_rec=0, drop_cnt=0, overflow=0, timestamp counter=0. RESET dominates all other inputs.
- Push latency: a retirement sampled at edge N is visible on trace_rec, with trace_valid high, from edge N onward (one-cycle capture latency).
- State changes take effect at the sampling edge. The next cycle's retirements are evaluated in the new state.
- The sink may hold trace_ready high continuously. This gives one record per cycle sustained throughput.
- trace_rec and trace_valid must stay stable while trace_valid && !trace_ready.
- Reset mid-capture discards all FIFO contents at the next edge.

## Configuration
- TRACE_TIMESTAMP_EN defined:
  - A free-running 32-bit cycle counter runs from reset, incrementing every cycle and wrapping at 2^32.
  - trace_rec_t gains a 32-bit timestamp field holding the counter value on the retirement cycle.
- TRACE_TIMESTAMP_EN undefined: no counter and no field. Behaviour is otherwise identical.

## Structure
- Package trace_pkg:
  - trace_rec_t: packed struct with pc, insn, rd_addr, rd_wdata, mem_addr, mem_rmask, mem_wmask, plus timestamp under the macro.
  - trace_state_e: IDLE, ARMED, CAPTURE, STOPPED.
- Sub-module trace_fifo: synchronous FIFO parameterised by DEPTH and element type, with push/pop/full/empty/count outputs. All window and drop logic stays in rvfi_trace_ctrl.

## Test plan
- Window: arm with start_pc=0x100, stop_pc=0x10C; retire 0xFC,0x100,0x104,0x108,0x10C,0x110 with trace_ready=1 → exactly 4 records, PCs 0x100..0x10C, then state_o=3.
- Overflow: DEPTH=8, trace_ready=0, 12 retirements in CAPTURE → fifo_count=8, drop_cnt=4, overflow=1; then ready=1 → 8 records drain in order.
- Full plus simultaneous push/pop: FIFO full, retire one with trace_ready=1 → no drop, count stays 8.
- start_pc==stop_pc=0x200: arm, retire 0x200,0x204 → one record (0x200), state STOPPED. Re-arm → drop_cnt=0, overflow=0, FIFO untouched.
- cfg_stop and cfg_arm pulsed together in ARMED → STOPPED; RESET low mid-CAPTURE with 5 queued → next cycle state IDLE, count 0, trace_valid 0.
- With TRACE_TIMESTAMP_EN defined, retirements at cycles 10 and 13 after reset → timestamps 10 and 13.
